// File: rtl/fmap_wr_seq_4lane_if.sv
// Bus bundle between the 4-lane write sequencer, the upstream PE lanes and the feature-map buffer.
// The master modport is the sequencer side; the slave modport is the PE/buffer environment side.
interface fmap_wr_seq_4lane_if #(
   parameter int DW           = 8,
   parameter int MEM_ADDR_ROW = 5,
   parameter int MEM_ADDR_COL = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic [DW-1:0]           data_in1;
   logic [DW-1:0]           data_in2;
   logic [DW-1:0]           data_in3;
   logic [DW-1:0]           data_in4;
   logic                    rd_busy;
   logic                    wr_en;
   logic [DW-1:0]           data_out1;
   logic [DW-1:0]           data_out2;
   logic [DW-1:0]           data_out3;
   logic [DW-1:0]           data_out4;
   logic [MEM_ADDR_ROW-1:0] add_row1;
   logic [MEM_ADDR_ROW-1:0] add_row2;
   logic [MEM_ADDR_ROW-1:0] add_row3;
   logic [MEM_ADDR_ROW-1:0] add_row4;
   logic [MEM_ADDR_COL-1:0] add_col1;
   logic [MEM_ADDR_COL-1:0] add_col2;
   logic [MEM_ADDR_COL-1:0] add_col3;
   logic [MEM_ADDR_COL-1:0] add_col4;

   modport master (
      input  in_valid, data_in1, data_in2, data_in3, data_in4, rd_busy,
      output in_ready, wr_en,
      output data_out1, data_out2, data_out3, data_out4,
      output add_row1, add_row2, add_row3, add_row4,
      output add_col1, add_col2, add_col3, add_col4
   );

   modport slave (
      output in_valid, data_in1, data_in2, data_in3, data_in4, rd_busy,
      input  in_ready, wr_en,
      input  data_out1, data_out2, data_out3, data_out4,
      input  add_row1, add_row2, add_row3, add_row4,
      input  add_col1, add_col2, add_col3, add_col4
   );
endinterface

// File: rtl/fmap_wr_seq_4lane.sv
// Write-side sequencer for the feature-map buffer: places 4-lane beats at consecutive
// row-major locations through a registered single-entry output stage, yielding to buffer reads.
module fmap_wr_seq_4lane #(
   parameter int DW           = 8,
   parameter int MEM_SIZE_ROW = 28,
   parameter int MEM_SIZE_COL = 7,
   parameter int MEM_ADDR_ROW = 5,
   parameter int MEM_ADDR_COL = 3,
   parameter int BEATS        = MEM_SIZE_ROW * MEM_SIZE_COL / 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   fmap_wr_seq_4lane_if.master bus
);

   localparam int CNT_W = $clog2(BEATS + 1);
   localparam int SUM_W = MEM_ADDR_COL + 1;
   localparam logic [SUM_W-1:0] COL_LIMIT = SUM_W'(MEM_SIZE_COL);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [MEM_ADDR_ROW-1:0] base_row;
   logic [MEM_ADDR_COL-1:0] base_col;
   logic [CNT_W-1:0]        beat_cnt;
   logic                    last_taken;
   logic                    pending;
   logic                    done_q;

   logic [DW-1:0]           data_q [4];
   logic [MEM_ADDR_ROW-1:0] row_q  [4];
   logic [MEM_ADDR_COL-1:0] col_q  [4];

   logic [DW-1:0]           lane_data [4];
   logic [SUM_W-1:0]        col_sum   [5];
   logic [MEM_ADDR_ROW-1:0] lane_row  [5];
   logic [MEM_ADDR_COL-1:0] lane_col  [5];

   logic accept;
   logic final_beat;
   logic enter_fill;
   logic write_done;

   assign lane_data[0] = bus.data_in1;
   assign lane_data[1] = bus.data_in2;
   assign lane_data[2] = bus.data_in3;
   assign lane_data[3] = bus.data_in4;

   assign enter_fill   = start && (state != ST_FILL);
   assign bus.in_ready = (state == ST_FILL) && !bus.rd_busy && !last_taken;
   assign accept       = bus.in_valid && bus.in_ready;
   assign final_beat   = accept && (beat_cnt == LAST_BEAT);
   assign write_done   = pending && !bus.rd_busy;
   assign bus.wr_en    = write_done;
   assign busy         = (state == ST_FILL);
   assign done         = done_q;

   // Entries 0..3 are the lane addresses of this beat; entry 4 is the next beat's base.
   always_comb begin
      for (int n = 0; n < 5; n++) begin
         col_sum[n]  = {1'b0, base_col} + SUM_W'(n);
         lane_row[n] = base_row;
         lane_col[n] = col_sum[n][MEM_ADDR_COL-1:0];
         if (col_sum[n] >= COL_LIMIT) begin
            lane_row[n] = base_row + MEM_ADDR_ROW'(1);
            lane_col[n] = MEM_ADDR_COL'(col_sum[n] - COL_LIMIT);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start)      state_next = ST_FILL;
         ST_FILL: if (final_beat) state_next = ST_DONE;
         ST_DONE: if (start)      state_next = ST_FILL;
         default:                 state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_row   <= '0;
         base_col   <= '0;
         beat_cnt   <= '0;
         last_taken <= 1'b0;
      end else if (enter_fill) begin
         base_row   <= '0;
         base_col   <= '0;
         beat_cnt   <= '0;
         last_taken <= 1'b0;
      end else if (accept) begin
         base_row <= lane_row[4];
         base_col <= lane_col[4];
         beat_cnt <= beat_cnt + CNT_W'(1);
         if (final_beat) begin
            last_taken <= 1'b1;
         end
      end
   end

   // A new accept reloads the stage in the same edge its previous write retires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            data_q[n] <= '0;
            row_q[n]  <= '0;
            col_q[n]  <= '0;
         end
      end else if (accept) begin
         pending <= 1'b1;
         for (int n = 0; n < 4; n++) begin
            data_q[n] <= lane_data[n];
            row_q[n]  <= lane_row[n];
            col_q[n]  <= lane_col[n];
         end
      end else if (write_done) begin
         pending <= 1'b0;
      end
   end

   // Once the final beat is taken, the only write still in flight is that final beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
      end else if (enter_fill) begin
         done_q <= 1'b0;
      end else if (write_done && last_taken) begin
         done_q <= 1'b1;
      end
   end

   assign bus.data_out1 = data_q[0];
   assign bus.data_out2 = data_q[1];
   assign bus.data_out3 = data_q[2];
   assign bus.data_out4 = data_q[3];
   assign bus.add_row1  = row_q[0];
   assign bus.add_row2  = row_q[1];
   assign bus.add_row3  = row_q[2];
   assign bus.add_row4  = row_q[3];
   assign bus.add_col1  = col_q[0];
   assign bus.add_col2  = col_q[1];
   assign bus.add_col3  = col_q[2];
   assign bus.add_col4  = col_q[3];

endmodule

// File: tb/tb_fmap_wr_seq_4lane.sv
// Bench for the 4-lane write sequencer: random beats against a linear-index model of the
// 28x7 buffer, with a write scoreboard and directed address/reset/stall scenarios.
module tb_fmap_wr_seq_4lane;

   localparam int DW      = 8;
   localparam int ROWS    = 28;
   localparam int COLS    = 7;
   localparam int AR      = 5;
   localparam int AC      = 3;
   localparam int ENTRIES = ROWS * COLS;
   localparam int BEATS   = ENTRIES / 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic busy;
   logic done;

   fmap_wr_seq_4lane_if #(.DW(DW), .MEM_ADDR_ROW(AR), .MEM_ADDR_COL(AC)) bus ();

   fmap_wr_seq_4lane #(
      .DW(DW), .MEM_SIZE_ROW(ROWS), .MEM_SIZE_COL(COLS),
      .MEM_ADDR_ROW(AR), .MEM_ADDR_COL(AC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .busy (busy),
      .done (done),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          k;
      logic [31:0] lanes;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] exp_mem [ENTRIES];
   logic [7:0] got_mem [ENTRIES];
   int         got_cnt [ENTRIES];

   int errors  = 0;
   int checks  = 0;
   bit m_fill  = 1'b0;
   bit m_done  = 1'b0;
   bit done_due = 1'b0;
   int m_beats = 0;
   int m_k     = 0;
   int run_len = 0;
   int max_run = 0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dut_data(input int n);
      case (n)
         0:       return bus.data_out1;
         1:       return bus.data_out2;
         2:       return bus.data_out3;
         default: return bus.data_out4;
      endcase
   endfunction

   function automatic logic [AR-1:0] dut_row(input int n);
      case (n)
         0:       return bus.add_row1;
         1:       return bus.add_row2;
         2:       return bus.add_row3;
         default: return bus.add_row4;
      endcase
   endfunction

   function automatic logic [AC-1:0] dut_col(input int n);
      case (n)
         0:       return bus.add_col1;
         1:       return bus.add_col2;
         2:       return bus.add_col3;
         default: return bus.add_col4;
      endcase
   endfunction

   function automatic logic [19:0] rows_now();
      return {bus.add_row4, bus.add_row3, bus.add_row2, bus.add_row1};
   endfunction

   function automatic logic [11:0] cols_now();
      return {bus.add_col4, bus.add_col3, bus.add_col2, bus.add_col1};
   endfunction

   function automatic logic [31:0] data_now();
      return {bus.data_out4, bus.data_out3, bus.data_out2, bus.data_out1};
   endfunction

   // Whatever sits in the pending stage must be on the write ports, and is written when rd_busy is low.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         check_output("wr_en", 32'(bus.wr_en), 32'((exp_q.size() > 0) && !bus.rd_busy));
         if (exp_q.size() > 0) begin
            for (int n = 0; n < 4; n++) begin
               check_output("lane_row",  32'(dut_row(n)),  32'((exp_q[0].k + n) / COLS));
               check_output("lane_col",  32'(dut_col(n)),  32'((exp_q[0].k + n) % COLS));
               check_output("lane_data", 32'(dut_data(n)), 32'(exp_q[0].lanes[8*n +: 8]));
            end
            if (!bus.rd_busy) begin
               for (int n = 0; n < 4; n++) begin
                  got_mem[exp_q[0].k + n] = dut_data(n);
                  got_cnt[exp_q[0].k + n]++;
               end
               if (exp_q[0].k == ENTRIES - 4) done_due = 1'b1;
               void'(exp_q.pop_front());
               run_len++;
               if (run_len > max_run) max_run = run_len;
            end else begin
               run_len = 0;
            end
         end else begin
            run_len = 0;
         end
      end
   end

   // One clock cycle: drive inputs, check in_ready mid-cycle, advance the model at the edge.
   task automatic apply_stimulus(input logic st, input logic vld, input logic [31:0] lanes, input logic rb);
      logic exp_ready;
      logic accepted;
      logic st_eff;
      start        = st;
      bus.in_valid = vld;
      bus.rd_busy  = rb;
      {bus.data_in4, bus.data_in3, bus.data_in2, bus.data_in1} = lanes;
      @(negedge clk);
      exp_ready = m_fill && !rb && (m_beats < BEATS);
      check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      accepted = vld && exp_ready;
      st_eff   = st && !m_fill;
      @(posedge clk);
      if (accepted) begin
         exp_q.push_back('{k: m_k, lanes: lanes});
         for (int n = 0; n < 4; n++) exp_mem[m_k + n] = lanes[8*n +: 8];
         m_k += 4;
         m_beats++;
         if (m_beats == BEATS) m_fill = 1'b0;
      end
      if (done_due) begin
         m_done   = 1'b1;
         done_due = 1'b0;
      end
      if (st_eff) begin
         m_fill  = 1'b1;
         m_done  = 1'b0;
         m_beats = 0;
         m_k     = 0;
         for (int i = 0; i < ENTRIES; i++) begin
            got_cnt[i] = 0;
            got_mem[i] = '0;
            exp_mem[i] = '0;
         end
      end
      #1;
      check_output("busy", 32'(busy), 32'(m_fill));
      check_output("done", 32'(done), 32'(m_done));
   endtask

   task automatic check_all_zero();
      check_output("rst_wr_en",    32'(bus.wr_en),    32'd0);
      check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_output("rst_done",     32'(done),         32'd0);
      check_output("rst_busy",     32'(busy),         32'd0);
      check_output("rst_data",     data_now(),        32'd0);
      check_output("rst_rows",     32'(rows_now()),   32'd0);
      check_output("rst_cols",     32'(cols_now()),   32'd0);
   endtask

   task automatic check_scoreboard(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (got_cnt[i] != 1 || got_mem[i] !== exp_mem[i]) bad++;
      end
      check_output(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  cyc;
      bit  start_pulsed;
      bit  stalled;
      logic vld;
      bus.in_valid = 1'b0;
      bus.rd_busy  = 1'b0;
      {bus.data_in4, bus.data_in3, bus.data_in2, bus.data_in1} = '0;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero();
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);

      // Fill 1: directed first beats, then random gaps, a stray start and a read stall.
      apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 32'h44332211, 1'b0);
      check_output("b1_wr_en", 32'(bus.wr_en), 32'd1);
      check_output("b1_rows",  32'(rows_now()), 32'({5'd0, 5'd0, 5'd0, 5'd0}));
      check_output("b1_cols",  32'(cols_now()), 32'({3'd3, 3'd2, 3'd1, 3'd0}));
      check_output("b1_data",  data_now(), 32'h44332211);
      check_output("b1_busy",  32'(busy), 32'd1);
      apply_stimulus(1'b0, 1'b1, 32'h88776655, 1'b0);
      check_output("b2_rows",  32'(rows_now()), 32'({5'd1, 5'd0, 5'd0, 5'd0}));
      check_output("b2_cols",  32'(cols_now()), 32'({3'd0, 3'd6, 3'd5, 3'd4}));
      apply_stimulus(1'b0, 1'b1, 32'hCCBBAA99, 1'b0);
      check_output("b3_rows",  32'(rows_now()), 32'({5'd1, 5'd1, 5'd1, 5'd1}));
      check_output("b3_cols",  32'(cols_now()), 32'({3'd4, 3'd3, 3'd2, 3'd1}));

      cyc = 0;
      start_pulsed = 1'b0;
      stalled = 1'b0;
      while (m_beats < BEATS && cyc < 1000) begin
         if (m_beats == 16 && exp_q.size() > 0 && !stalled) begin
            repeat (3) apply_stimulus(1'b0, 1'b1, $urandom, 1'b1);
            stalled = 1'b1;
         end else begin
            vld = ($urandom_range(0, 3) != 0);
            if (m_beats == 10 && vld && !start_pulsed) begin
               start_pulsed = 1'b1;
               apply_stimulus(1'b1, vld, $urandom, 1'b0);
            end else begin
               apply_stimulus(1'b0, vld, $urandom, 1'b0);
            end
         end
         cyc++;
      end
      check_output("fill1_beats", 32'(m_beats), 32'(BEATS));
      repeat (3) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
      check_output("fill1_done", 32'(done), 32'd1);
      check_scoreboard("fill1_scoreboard");

      // Fill 2: restart from DONE, then 49 back-to-back beats.
      apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
      check_output("restart_done", 32'(done), 32'd0);
      max_run = 0;
      for (int b = 0; b < BEATS; b++) begin
         apply_stimulus(1'b0, 1'b1, $urandom, 1'b0);
         if (b == 0) begin
            check_output("f2_first_rows", 32'(rows_now()), 32'd0);
            check_output("f2_first_cols", 32'(cols_now()), 32'({3'd3, 3'd2, 3'd1, 3'd0}));
         end
      end
      check_output("f2_last_wr_en", 32'(bus.wr_en), 32'd1);
      check_output("f2_last_rows",  32'(rows_now()), 32'({5'd27, 5'd27, 5'd27, 5'd27}));
      check_output("f2_last_cols",  32'(cols_now()), 32'({3'd6, 3'd5, 3'd4, 3'd3}));
      apply_stimulus(1'b0, 1'b1, $urandom, 1'b0);
      check_output("f2_done",  32'(done), 32'd1);
      check_output("f2_busy",  32'(busy), 32'd0);
      repeat (2) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
      check_output("f2_wr_run", 32'(max_run), 32'(BEATS));
      check_scoreboard("fill2_scoreboard");

      // Fill 3: reset lands while beat 20 is pending.
      apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
      repeat (20) apply_stimulus(1'b0, 1'b1, $urandom, 1'b0);
      check_output("f3_pending", 32'(bus.wr_en), 32'd1);
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_all_zero();
      exp_q.delete();
      m_fill   = 1'b0;
      m_done   = 1'b0;
      done_due = 1'b0;
      m_beats  = 0;
      m_k      = 0;
      repeat (2) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
      reset = 1'b1;
      apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      check_output("post_rst_row1", 32'(bus.add_row1), 32'd0);
      check_output("post_rst_col1", 32'(bus.add_col1), 32'd0);
      check_output("post_rst_data", data_now(), 32'hDEADBEEF);
      repeat (2) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fmap_wr_seq_4lane.md
Name: fmap_wr_seq_4lane

Overview:
- Write-side sequencer for the 28x7 feature-map buffer, which has 4 write ports.
- Accepts beats of 4 parallel 8-bit results from the upstream PE lanes through a valid/ready handshake.
- Assigns each lane the next linear buffer location in row-major order, with 4 consecutive indices per beat.
- Drives the buffer's 4 data/row/col write ports and wr_en from a registered output stage, and flags done once all 196 entries are written.

Parameters:
DW, 8, data width per lane
MEM_SIZE_ROW, 28, buffer rows
MEM_SIZE_COL, 7, buffer columns; must be >= 4
MEM_ADDR_ROW, 5, row address width
MEM_ADDR_COL, 3, column address width
BEATS, MEM_SIZE_ROW*MEM_SIZE_COL/4 (=49), beats per fill; product must be a multiple of 4

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a fill
in_valid  in  1  upstream beat valid
in_ready  out  1  sequencer can accept a beat
data_in1..data_in4  in  DW each  lane data, lane1 = lowest index
rd_busy  in  1  buffer read in progress; writes must not be issued
wr_en  out  1  write strobe to buffer
data_out1..data_out4  out  DW each  write data to buffer ports 1..4
add_row1..add_row4  out  MEM_ADDR_ROW each  write row per port
add_col1..add_col4  out  MEM_ADDR_COL each  write col per port
busy  out  1  high in FILL state
done  out  1  level, buffer fully written

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0, including wr_en, in_ready, done, data_out*, add_row*, add_col*. Base pointers (row, col) = (0,0); beat_cnt = 0.
- States are IDLE, FILL and DONE.
  - IDLE, start=1 -> FILL.
  - FILL, final beat accepted -> DONE.
  - DONE, start=1 -> FILL.
  - start in FILL is ignored.
  - Entering FILL clears done, base = (0,0) and beat_cnt = 0.
- in_ready (combinational) = (state==FILL) && !rd_busy && !last_taken. last_taken is set when beat BEATS-1 is accepted.
- Accept means in_valid && in_ready at a rising edge. At that edge:
  - the output stage loads data_outN = data_inN and the lane addresses;
  - the stage is marked pending;
  - base advances by 4 and beat_cnt increments.
- Lane address for lane n (n = 0..3) is base col c + n.
  - If c+n < MEM_SIZE_COL: (row, c+n).
  - Otherwise: (row+1, c+n-MEM_SIZE_COL).
  - At most one row wrap per lane.
  - Base advance uses the same wrap rule with n=4.
- wr_en (combinational) = pending && !rd_busy. This makes buffer writes mutually exclusive with reads.
- The pending stage stalls while rd_busy=1: data and addresses are held, and in_ready=0 because rd_busy=1.
- At an edge where pending && !rd_busy, the write completes and pending clears, unless a new accept reloads the stage in the same edge. Back-to-back accepts therefore give one write per cycle.
- Latency: beat accepted at edge E0 -> wr_en high in cycle E0..E1 (if rd_busy=0) -> buffer captures at E1.
- done rises at the edge where the final pending write completes, and stays high until the next start.
- busy = (state==FILL).
- When wr_en=0, data_out* and add_* hold their last values.
- Reset mid-fill: everything returns to the reset values, and any pending write is dropped (wr_en=0 immediately). Already-written buffer contents are not this block's concern.
- in_valid is ignored outside FILL.
- beat_cnt width = clog2(BEATS+1).

Test Plan:
- Reset, pulse start, present 1 beat of lanes 0x11,0x22,0x33,0x44 -> next cycle wr_en=1 with addresses (0,0),(0,1),(0,2),(0,3) and data 0x11..0x44; busy=1, done=0.
- Second beat -> addresses (0,4),(0,5),(0,6),(1,0). Third beat -> (1,1)..(1,4).
- 49 back-to-back beats with in_valid held 1:
  - the final write is at (27,3),(27,4),(27,5),(27,6);
  - wr_en is high for 49 consecutive cycles;
  - in_ready drops after the 49th accept;
  - done=1 the edge after the last wr_en;
  - state DONE, busy=0.
- Raise rd_busy for 3 cycles while a beat is pending:
  - wr_en=0 and in_ready=0 during those cycles;
  - data and addresses are held;
  - the write issues in the first cycle after rd_busy falls, with no beat lost or duplicated, checked by a scoreboard of 196 entries.
- Pulse start mid-fill (beat 10) -> ignored, base continues. Pulse start in DONE -> done=0, next write is at (0,0).
- Assert reset at beat 20 with pending=1 -> wr_en, done, in_ready and all outputs 0 asynchronously. After release plus start, the first write is at (0,0).
